// File: rtl/clock_pkg.sv
// Shared clock-section types and constants (BCD digits, minute limit, reset value).
// Also used by the hour section.
package clock_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef struct packed {
      bcd_digit_t tens;
      bcd_digit_t units;
   } bcd2_t;

   localparam logic [7:0] MIN_MAX_BCD = 8'h59;
   localparam logic [7:0] BCD_RESET   = 8'h00;

   // Converts a 0..99 binary value into two packed BCD digits.
   function automatic logic [7:0] to_bcd2(input int value);
      logic [7:0] r;
      r[7:4] = 4'(value / 10);
      r[3:0] = 4'(value % 10);
      return r;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer for an asynchronous level, with a one-cycle rising-edge pulse.
// The pulse is asserted SYNC_STAGES-1 cycles after the first sampling edge. STAGES must be >= 2.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;
   logic              w_sync;

   assign w_sync = r_sync[STAGES-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
         r_prev <= w_sync;
      end
   end

   assign o_rise = w_sync & ~r_prev;

endmodule

// File: rtl/minute_control.sv
// Minute section of a digital clock: BCD 00..MAX_COUNT, run mode counts every tick with a
// one-cycle CARRY on wrap; set mode advances only on synchronized MIN_INCR presses.
module minute_control
   import clock_pkg::*;
#(
   parameter int MAX_COUNT   = 59,
   parameter int SYNC_STAGES = 2
) (
   input  logic       MIN_CLK,
   input  logic       RST_N,
   input  logic       MIN_INCR,
   input  logic       MIN_SET,
   output logic       CARRY,
   output logic [7:0] MINUTE
);

   localparam logic [7:0] MAX_BCD = (MAX_COUNT == 59) ? MIN_MAX_BCD : to_bcd2(MAX_COUNT);

   bcd2_t                  r_minute;
   logic                   r_carry;
   logic [SYNC_STAGES-1:0] r_set_sync;
   logic                   w_set_s;
   logic                   w_incr_pulse;

   // Any non-BCD digit or value at/above the limit recovers to 00 on the next increment.
   function automatic bcd2_t bcd_inc(input bcd2_t v, input logic [7:0] max_v);
      bcd2_t n;
      n = BCD_RESET;
      if ((v.units > 4'd9) || (v.tens > 4'd9) || (v >= max_v)) begin
         n = BCD_RESET;
      end else if (v.units == 4'd9) begin
         n.tens  = v.tens + 4'd1;
         n.units = 4'd0;
      end else begin
         n.tens  = v.tens;
         n.units = v.units + 4'd1;
      end
      return n;
   endfunction

   sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_incr_sync (
      .i_clk   (MIN_CLK),
      .i_rst_n (RST_N),
      .i_async (MIN_INCR),
      .o_rise  (w_incr_pulse)
   );

   assign w_set_s = r_set_sync[SYNC_STAGES-1];

   always_ff @(posedge MIN_CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_minute   <= BCD_RESET;
         r_carry    <= 1'b0;
         r_set_sync <= '0;
      end else begin
         r_set_sync <= {r_set_sync[SYNC_STAGES-2:0], MIN_SET};
         if (!w_set_s) begin
            r_minute <= bcd_inc(r_minute, MAX_BCD);
            r_carry  <= (r_minute == MAX_BCD);
         end else begin
            r_carry <= 1'b0;
            if (w_incr_pulse) begin
               r_minute <= bcd_inc(r_minute, MAX_BCD);
            end
         end
      end
   end

   assign MINUTE = r_minute;
   assign CARRY  = r_carry;

endmodule

// File: tb/tb_minute_control.sv
// Scoreboard bench for minute_control: each task pushes the expected MINUTE/CARRY per clock
// and pops/compares one entry per rising edge.
module tb_minute_control;

   localparam int SYNC = 2;

   typedef struct {
      logic [7:0] min;
      logic       carry;
   } exp_t;

   logic       MIN_CLK = 1'b0;
   logic       RST_N;
   logic       MIN_INCR;
   logic       MIN_SET;
   logic       CARRY;
   logic [7:0] MINUTE;

   exp_t  exp_q[$];
   int    pass_cnt  = 0;
   int    total_cnt = 0;
   int    cur       = 0;
   string tname     = "init";

   minute_control #(
      .MAX_COUNT   (59),
      .SYNC_STAGES (SYNC)
   ) dut (
      .MIN_CLK  (MIN_CLK),
      .RST_N    (RST_N),
      .MIN_INCR (MIN_INCR),
      .MIN_SET  (MIN_SET),
      .CARRY    (CARRY),
      .MINUTE   (MINUTE)
   );

   always #5 MIN_CLK = ~MIN_CLK;

   function automatic logic [7:0] bcd(input int n);
      logic [7:0] r;
      r[7:4] = 4'(n / 10);
      r[3:0] = 4'(n % 10);
      return r;
   endfunction

   task automatic push(input logic [7:0] m, input logic c);
      exp_t e;
      e.min   = m;
      e.carry = c;
      exp_q.push_back(e);
   endtask

   // Advance one clock and compare the DUT against the oldest expectation.
   task automatic step();
      exp_t e;
      @(posedge MIN_CLK);
      #1;
      total_cnt++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s: scoreboard empty, MINUTE=%h CARRY=%b", tname, MINUTE, CARRY);
      end else begin
         e = exp_q.pop_front();
         if (MINUTE !== e.min || CARRY !== e.carry)
            $display("FAIL %s: MINUTE=%h CARRY=%b, expected MINUTE=%h CARRY=%b",
                     tname, MINUTE, CARRY, e.min, e.carry);
         else
            pass_cnt++;
      end
   endtask

   task automatic run_steps(input int n);
      for (int i = 0; i < n; i++) begin
         cur = (cur + 1) % 60;
         push(bcd(cur), cur == 0);
         step();
      end
   endtask

   task automatic hold_steps(input int n);
      for (int i = 0; i < n; i++) begin
         push(bcd(cur), 1'b0);
         step();
      end
   endtask

   task automatic enter_set();
      MIN_SET = 1'b1;
      run_steps(SYNC);
   endtask

   task automatic exit_set();
      MIN_SET = 1'b0;
      hold_steps(SYNC);
   endtask

   // From run mode, count so that set mode latches exactly at 'target'.
   task automatic goto_set(input int target);
      run_steps((((target - SYNC - cur) % 60) + 60) % 60);
      enter_set();
   endtask

   task automatic press(input int hi);
      MIN_INCR = 1'b1;
      for (int i = 0; i < hi + SYNC + 1; i++) begin
         if (i == hi) MIN_INCR = 1'b0;
         if (i == SYNC) cur = (cur + 1) % 60;
         push(bcd(cur), 1'b0);
         step();
      end
   endtask

   task automatic test_reset();
      tname    = "reset";
      RST_N    = 1'b0;
      MIN_SET  = 1'b0;
      MIN_INCR = 1'b0;
      #2;
      total_cnt++;
      if (MINUTE !== 8'h00 || CARRY !== 1'b0)
         $display("FAIL reset_initial: MINUTE=%h CARRY=%b, expected 00/0", MINUTE, CARRY);
      else
         pass_cnt++;
      @(posedge MIN_CLK);
      #1;
      RST_N = 1'b1;
      cur   = 0;
      run_steps(37);
      #3;
      RST_N = 1'b0;
      #1;
      total_cnt++;
      if (MINUTE !== 8'h00 || CARRY !== 1'b0)
         $display("FAIL reset_async: MINUTE=%h CARRY=%b, expected 00/0", MINUTE, CARRY);
      else
         pass_cnt++;
      cur = 0;
      @(posedge MIN_CLK);
      #1;
      total_cnt++;
      if (MINUTE !== 8'h00)
         $display("FAIL reset_hold: MINUTE=%h, expected 00", MINUTE);
      else
         pass_cnt++;
      RST_N = 1'b1;
      tname = "reset_release";
      run_steps(1);
   endtask

   task automatic test_run_wrap();
      tname = "run_wrap";
      run_steps(125);
   endtask

   task automatic test_set_single();
      tname = "set_single";
      goto_set(9);
      hold_steps(2);
      press(3);
   endtask

   task automatic test_set_wrap();
      tname = "set_wrap";
      exit_set();
      goto_set(58);
      press(3);
      press(3);
   endtask

   // MIN_INCR toggles at +7/+12 ns after each edge, so every edge samples it high:
   // a single detected rise, hence a single increment.
   task automatic test_set_toggle();
      tname = "set_toggle";
      fork
         begin
            #6;
            repeat (60) begin
               MIN_INCR = ~MIN_INCR;
               #5;
            end
         end
         begin
            for (int i = 0; i < 30; i++) begin
               if (i == SYNC) cur = (cur + 1) % 60;
               push(bcd(cur), 1'b0);
               step();
            end
         end
      join
      MIN_INCR = 1'b0;
      tname = "toggle_resume";
      exit_set();
      run_steps(5);
   endtask

   task automatic test_mode_switch();
      tname = "mode_switch";
      goto_set(59);
      hold_steps(3);
      exit_set();
      run_steps(2);
      tname = "carry_into_set";
      goto_set(0);
      hold_steps(2);
      exit_set();
      run_steps(3);
   endtask

   initial begin
      test_reset();
      test_run_wrap();
      test_set_single();
      test_set_wrap();
      test_set_toggle();
      test_mode_switch();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/minute_control.md
Name: minute_control

Overview:
Minute section of a digital clock. Holds the current minute as two BCD digits, 00–59.
- Run mode: advances once per MIN_CLK cycle, where MIN_CLK is the minute tick. Emits a one-cycle CARRY on the 59→00 wrap to the hour section.
- Set mode: advances only on user presses of MIN_INCR, with no carry.

Parameters:
- MAX_COUNT, 59: highest minute value; the count wraps to 0 after it. Legal range 1..99.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers on MIN_INCR and MIN_SET. Minimum 2.

Ports:
- MIN_CLK, input, 1: the single clock (minute tick). All state changes on its rising edge.
- RST_N, input, 1: asynchronous active-low reset.
- MIN_INCR, input, 1: asynchronous manual-increment request, e.g. a pushbutton. Acts on its rising edge.
- MIN_SET, input, 1: asynchronous mode select. 1 = set mode, 0 = run mode.
- CARRY, output, 1: registered one-cycle pulse on the run-mode wrap.
- MINUTE, output, 8: BCD minute, registered. [7:4] = tens digit (0–5), [3:0] = units digit (0–9).

Behaviour:
Reset
- While RST_N=0, asynchronously: MINUTE=8'h00, CARRY=0, all synchronizer and edge-detect flops cleared to 0.
- Count resumes on the first rising edge of MIN_CLK after RST_N deasserts.

Input synchronization
- MIN_INCR and MIN_SET each pass through a SYNC_STAGES-deep flop chain. Names: incr_s, set_s.
- An edge-detect flop holds the previous incr_s. incr_pulse = incr_s & ~incr_prev, lasting one cycle.
- A MIN_INCR rising edge first sampled at edge k gives incr_pulse during cycle k+SYNC_STAGES-1. MINUTE updates at edge k+SYNC_STAGES.
- MIN_INCR held high gives exactly one increment; no auto-repeat.

Run mode (set_s=0)
- Every rising edge: MINUTE increments by 1 in BCD.
- Units 9 → 0 with tens+1.
- Value equal to MAX_COUNT (BCD) → 00.
- CARRY is set to 1 on the same edge that loads 00 from MAX_COUNT; cleared on the next edge. It is high for exactly one cycle, coincident with MINUTE=00.
- incr_pulse is ignored in run mode.

Set mode (set_s=1)
- MINUTE increments by 1 only on edges where incr_pulse=1; otherwise it holds.
- Same BCD and wrap rules as run mode. CARRY is forced to 0, including on a wrap.

Mode changes
- Take effect using set_s, i.e. after the synchronizer latency.
- A CARRY already high when set mode begins clears on the next edge, as normal.
- The edge-detect flop runs in both modes. A MIN_INCR edge that occurs while in run mode does not cause a later increment.

Illegal state
- A units digit >9 or a tens digit >5 (for the default MAX_COUNT) must never be produced.
- If reached anyway, the next increment loads 00.

Decomposition:
- Shared package clock_pkg: BCD digit typedef (4-bit), constant MIN_MAX_BCD = 8'h59, reset value constant 8'h00. The hour section reuses these.
- One natural sub-module: sync_edge, a parameterized N-stage synchronizer with rising-edge pulse output, instantiated for MIN_INCR.
- MIN_SET uses the synchronizer path only.
- The BCD increment/wrap is a function inside minute_control.

Test Plan:
1. Reset: drive RST_N=0 mid-count with MINUTE=8'h37 → MINUTE=8'h00 and CARRY=0 immediately, without waiting for a clock edge. Hold-off: on release, first increment on the next edge.
2. Run-mode count and wrap: MIN_SET=0, 10 ns clock, from 00 → MINUTE steps through 01..09, 10, ..., 59, 00. CARRY=1 for exactly the one cycle MINUTE=00 after 59; 60-cycle period; no BCD values like 8'h0A appear.
3. Set mode, single press: MIN_SET=1, MINUTE=8'h09, one MIN_INCR pulse of 3 cycles → MINUTE=8'h10 after SYNC_STAGES edges; no further change while MIN_INCR stays high; CARRY=0.
4. Set-mode wrap without carry: MINUTE=8'h58, two separate MIN_INCR presses → 59 then 00; CARRY stays 0 throughout.
5. Set mode with toggling increment: MIN_INCR toggles every 5 ns with a 2 ns offset against a 10 ns clock for 300 ns → exactly one increment per detected rising edge of the synchronized MIN_INCR; MINUTE never holds an illegal BCD value; after MIN_SET goes to 0, counting resumes one step per clock following the synchronizer latency.
6. Mode switch at the wrap: run mode at MINUTE=8'h59, raise MIN_SET so that set_s=1 on the wrap edge → MINUTE holds at 59, no CARRY; returning to run mode → 00 with a CARRY pulse.
